// File: rtl/pipelined_step_incrementer.sv
// Pipelined carry-select incrementer/decrementer by a power-of-two step, with
// optional saturation and valid/ready flow control over STAGES register stages.
module pipelined_step_incrementer #(
    parameter int LEN    = 32,
    parameter int SLICE  = 4,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LEN-1:0] value,
    input  logic [1:0]     step,
    input  logic           direction,
    input  logic           saturate,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] result,
    output logic           overflow
);

    localparam int NSL = (LEN + SLICE - 1) / SLICE;
    localparam int MS  = (STAGES > 1) ? STAGES - 1 : 1;

    function automatic int stage_of(input int i);
        return (i * STAGES) / NSL;
    endfunction

    logic [STAGES-1:0]          valid_q, valid_d;
    logic [STAGES-1:0][LEN-1:0] data_q, data_d;
    logic [STAGES-1:0]          carry_q, carry_d;
    logic [MS-1:0]              dir_q, dir_d;
    logic [MS-1:0]              sat_q, sat_d;
    logic [MS-1:0][1:0]         lo_q, lo_d;
    logic [MS-1:0][1:0]         mask_q, mask_d;
    logic                       advance_s;

    // Stage datapath: decrement is folded into increment by operating on the
    // inverted operand; bits below the step position are forced to ones so
    // the carry enters at bit k, and are restored from the operand at the end.
    always_comb begin
        logic [LEN-1:0]   x;
        logic [SLICE-1:0] sl;
        logic [SLICE-1:0] inc;
        logic             c;
        logic             dr;
        logic             st;
        logic             v;
        logic [1:0]       lo;
        logic [1:0]       m;
        int               p;
        int               sh;

        advance_s = !valid_q[STAGES-1] || out_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        carry_d   = carry_q;
        dir_d     = dir_q;
        sat_d     = sat_q;
        lo_d      = lo_q;
        mask_d    = mask_q;
        x         = '0;
        sl        = '0;
        inc       = '0;
        c         = 1'b0;
        dr        = 1'b0;
        st        = 1'b0;
        v         = 1'b0;
        lo        = 2'b00;
        m         = 2'b00;
        p         = 0;
        sh        = 0;

        for (int s = 0; s < STAGES; s++) begin
            p = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                case (step)
                    2'b00:   m = 2'b00;
                    2'b01:   m = 2'b01;
                    2'b10:   m = 2'b11;
                    default: m = 2'b00;
                endcase
                x  = (direction ? ~value : value) | {{(LEN-2){1'b0}}, m};
                c  = (step != 2'b11);
                dr = direction;
                st = saturate;
                lo = value[1:0];
                v  = in_valid;
            end else begin
                x  = data_q[p];
                c  = carry_q[p];
                dr = dir_q[p];
                st = sat_q[p];
                lo = lo_q[p];
                m  = mask_q[p];
                v  = valid_q[p];
            end

            for (int i = 0; i < NSL; i++) begin
                if (stage_of(i) == s) begin
                    sh  = i * SLICE;
                    // A narrow top slice is padded with ones so its all-ones flag stays exact.
                    sl  = SLICE'(x >> sh) | ~SLICE'({LEN{1'b1}} >> sh);
                    inc = sl + SLICE'(1);
                    if (c) begin
                        x = (x & ~(LEN'({SLICE{1'b1}}) << sh)) | (LEN'(inc) << sh);
                    end else begin
                        x = x;
                    end
                    c = c & (&sl);
                end else begin
                    c = c;
                end
            end

            if (s == STAGES - 1) begin
                x      = dr ? ~x : x;
                x[1:0] = (x[1:0] & ~m) | (lo & m);
                if (st && c) begin
                    x = dr ? {LEN{1'b0}} : {LEN{1'b1}};
                end else begin
                    x = x;
                end
            end else begin
                x = x;
            end

            if (advance_s) begin
                valid_d[s] = v;
                if (v) begin
                    data_d[s]  = x;
                    carry_d[s] = c;
                    if (s < STAGES - 1) begin
                        dir_d[s]  = dr;
                        sat_d[s]  = st;
                        lo_d[s]   = lo;
                        mask_d[s] = m;
                    end else begin
                        dir_d = dir_d;
                    end
                end else begin
                    data_d = data_d;
                end
            end else begin
                valid_d = valid_d;
            end
        end

        if (flush) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
            carry_q <= '0;
            dir_q   <= '0;
            sat_q   <= '0;
            lo_q    <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            lo_q    <= lo_d;
            mask_q  <= mask_d;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_q[STAGES-1];
    assign result    = data_q[STAGES-1];
    assign overflow  = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_step_incrementer.sv
// Randomized and directed bench for pipelined_step_incrementer against an
// arithmetic reference model and an in-order scoreboard.
module tb_pipelined_step_incrementer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value = 32'd0;
    logic [1:0]  step = 2'b00;
    logic        direction = 1'b0;
    logic        saturate = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;

    logic        in_valid30 = 1'b0;
    logic        in_ready30;
    logic [29:0] value30 = 30'd0;
    logic        out_valid30;
    logic [29:0] result30;
    logic        overflow30;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb_q[$];
    logic        held = 1'b0;
    logic [31:0] held_res = 32'd0;
    logic        held_ovf = 1'b0;

    always #5 clk = ~clk;

    pipelined_step_incrementer #(.LEN(32), .SLICE(4), .STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .value(value), .step(step), .direction(direction),
        .saturate(saturate), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    pipelined_step_incrementer #(.LEN(30), .SLICE(4), .STAGES(3)) u_dut30 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid30),
        .in_ready(in_ready30), .value(value30), .step(2'b00), .direction(1'b0),
        .saturate(1'b0), .out_valid(out_valid30), .out_ready(1'b1),
        .result(result30), .overflow(overflow30)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [31:0] v, input logic [1:0] st,
                                      input logic d, input logic s, input int len,
                                      output logic [31:0] r, output logic o);
        longint unsigned full, lim, up, lowv;
        int k;
        full = (64'd1 << len) - 64'd1;
        if (st == 2'b11) begin
            r = v;
            o = 1'b0;
            return;
        end
        k    = int'(st);
        lim  = 64'd1 << (len - k);
        up   = (64'(v) & full) >> k;
        lowv = 64'(v) & ((64'd1 << k) - 64'd1);
        if (!d) begin
            up = up + 64'd1;
            o  = (up == lim);
            if (o) up = 64'd0;
        end else begin
            o  = (up == 64'd0);
            up = o ? lim - 64'd1 : up - 64'd1;
        end
        r = 32'((up << k) | lowv);
        if (s && o) r = d ? 32'd0 : 32'(full);
    endfunction

    // Evaluate the handshake for the coming edge, then advance to the next negedge.
    task automatic cycle();
        logic [31:0] er;
        logic        eo;
        logic [32:0] e;
        #1;
        if (held) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_result", 64'(result), 64'(held_res));
            chk("stall_ovf", 64'(overflow), 64'(held_ovf));
        end
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("result", 64'(result), 64'(e[31:0]));
                chk("overflow", 64'(overflow), 64'(e[32]));
            end
        end
        held     = out_valid && !out_ready && !flush;
        held_res = result;
        held_ovf = overflow;
        if (flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            ref_model(value, step, direction, saturate, 32, er, eo);
            sb_q.push_back({eo, er});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] v, input logic [1:0] st,
                         input logic d, input logic s);
        in_valid  = iv;
        value     = v;
        step      = st;
        direction = d;
        saturate  = s;
    endtask

    initial begin
        #12;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Latency of exactly two cycles.
        drive(1'b1, 32'h0000_0FFF, 2'b00, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_cycle2", 64'(out_valid), 64'd1);
        chk("lat_result", 64'(result), 64'h0000_1000);
        cycle();
        chk("lat_empty", 64'(out_valid), 64'd0);

        // Overflow and saturation corners.
        drive(1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0, 1'b1); cycle();
        drive(1'b1, 32'h0000_0001, 2'b01, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h0000_0001, 2'b01, 1'b1, 1'b1); cycle();
        drive(1'b1, 32'h1234_5678, 2'b11, 1'b1, 1'b1); cycle();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        repeat (3) cycle();

        // Stream with a three-cycle stall.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i), 2'b00, 1'b0, 1'b0);
            if (i == 3) out_ready = 1'b0;
            cycle();
        end
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        repeat (2) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            cycle();
        end
        out_ready = 1'b1;
        repeat (4) cycle();

        // Flush with two operands in flight.
        drive(1'b1, 32'h0000_0100, 2'b00, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0000_0200, 2'b00, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h0000_0300, 2'b00, 1'b0, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h0000_0010, 2'b00, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        chk("post_flush_c1", 64'(out_valid), 64'd0);
        cycle();
        chk("post_flush_c2", 64'(out_valid), 64'd1);
        chk("post_flush_res", 64'(result), 64'h0000_0011);
        cycle();

        // Narrow top slice, three stages.
        in_valid30 = 1'b1;
        value30    = 30'h3FFF_FFFF;
        cycle();
        in_valid30 = 1'b0;
        cycle();
        chk("len30_c2", 64'(out_valid30), 64'd0);
        cycle();
        chk("len30_valid", 64'(out_valid30), 64'd1);
        chk("len30_result", 64'(result30), 64'd0);
        chk("len30_ovf", 64'(overflow30), 64'd1);
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] v;
            case ($urandom_range(0, 5))
                0:       v = 32'h0000_0000;
                1:       v = 32'hFFFF_FFFF;
                2:       v = 32'hFFFF_FFFC;
                3:       v = 32'h0000_0003;
                default: v = $urandom;
            endcase
            drive(($urandom_range(0, 3) != 0), v, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        repeat (4) cycle();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset mid-stream.
        drive(1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0); cycle();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_result", 64'(result), 64'd0);
        chk("areset_ovf", 64'(overflow), 64'd0);
        sb_q.delete();
        held = 1'b0;
        drive(1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
